// File: rtl/nrs_buf.sv
// nrs_buf -- responder-side buffer for the channel estimator's NRS read port.
//
// Collects serial NRS bit-pairs {real, imag} from the generator, one per
// accepted cycle. A page holds 4 columns x 2^NRS_ADDR entries, written in
// flat order {column, entry}. A full page is handed to the estimator
// (NRS_gen_ready). The estimator reads it with 1-cycle latency until it
// pulses est_ack_nrs, which frees the page.
//
// Build option: define NRS_PINGPONG_EN for two pages, so the generator can
// fill one page while the other is read. Without it there is a single page,
// and the generator is stalled from the last write until est_ack_nrs.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-low reset
//   gen_valid      in   generator presents a bit-pair
//   gen_nrs_r      in   real bit (1 = negative symbol)
//   gen_nrs_i      in   imaginary bit (1 = negative symbol)
//   gen_ready      out  write page is EMPTY or FILLING
//   wr_err         out  sticky: gen_valid seen while gen_ready low
//   nrs_index_addr in   read column select (0..3)
//   rd_addr_nrs    in   read entry select
//   est_ack_nrs    in   estimator done with the current read page
//   NRS_gen_ready  out  a full page is being served
//   nrs_r          out  registered real bit of the addressed entry
//   nrs_i          out  registered imaginary bit of the addressed entry
module nrs_buf #(
  parameter int unsigned NRS_ADDR = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                gen_valid,
  input  logic                gen_nrs_r,
  input  logic                gen_nrs_i,
  output logic                gen_ready,
  output logic                wr_err,
  input  logic [1:0]          nrs_index_addr,
  input  logic [NRS_ADDR-1:0] rd_addr_nrs,
  input  logic                est_ack_nrs,
  output logic                NRS_gen_ready,
  output logic                nrs_r,
  output logic                nrs_i
);

  localparam int unsigned AW    = NRS_ADDR + 2;
  localparam int unsigned DEPTH = 1 << AW;
`ifdef NRS_PINGPONG_EN
  localparam int unsigned NPG = 2;
`else
  localparam int unsigned NPG = 1;
`endif

  typedef enum logic [1:0] {
    PG_EMPTY,
    PG_FILLING,
    PG_FULL,
    PG_READING
  } pg_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_SERVE
  } rd_state_t;

  pg_state_t     r_pg_st  [NPG];
  pg_state_t     w_pg_nxt [NPG];
  rd_state_t     r_rd_st;
  rd_state_t     w_rd_nxt;
  logic [AW-1:0] r_wr_cnt;
  logic          r_wr_err;
  logic          r_nrs_r;
  logic          r_nrs_i;
  logic [1:0]    r_mem0 [DEPTH];

  logic          w_wr_pg;
  logic          w_rd_pg;
  logic          w_sel_vld;
  logic          w_sel_pg;
  logic          w_gen_ready;
  logic          w_wr_acc;
  logic          w_wr_last;
  logic          w_ack;
  logic          w_serve;
  logic [AW-1:0] w_rd_idx;
  logic [1:0]    w_rd_data;

  // ---------------------------------------------------------------------------
  // Page pointers: only the two-page build needs them; with one page both
  // pointers are tied to page 0.
  // ---------------------------------------------------------------------------
`ifdef NRS_PINGPONG_EN
  logic       r_wr_pg;
  logic       r_rd_pg;
  logic [1:0] r_mem1 [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_pg <= 1'b0;
      r_rd_pg <= 1'b0;
    end else begin
      if (w_wr_last)
        r_wr_pg <= ~r_wr_pg;
      if (r_rd_st == RD_IDLE && w_sel_vld)
        r_rd_pg <= w_sel_pg;
    end
  end

  assign w_wr_pg = r_wr_pg;
  assign w_rd_pg = r_rd_pg;
`else
  assign w_wr_pg = 1'b0;
  assign w_rd_pg = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  always_comb begin
    w_gen_ready = 1'b0;
    for (int unsigned p = 0; p < NPG; p++) begin
      if (p[0] == w_wr_pg &&
          (r_pg_st[p] == PG_EMPTY || r_pg_st[p] == PG_FILLING))
        w_gen_ready = 1'b1;
    end
  end

  assign w_wr_acc  = gen_valid & w_gen_ready;
  assign w_wr_last = w_wr_acc & (&r_wr_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_cnt <= '0;
      r_wr_err <= 1'b0;
    end else begin
      if (w_wr_acc)
        r_wr_cnt <= r_wr_cnt + 1'b1;
      if (gen_valid && !w_gen_ready)
        r_wr_err <= 1'b1;
    end
  end

  // Storage carries no reset; its contents are only meaningful once a page
  // has been completely written.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !w_wr_pg)
      r_mem0[r_wr_cnt] <= {gen_nrs_r, gen_nrs_i};
`ifdef NRS_PINGPONG_EN
    if (w_wr_acc && w_wr_pg)
      r_mem1[r_wr_cnt] <= {gen_nrs_r, gen_nrs_i};
`endif
  end

  // ---------------------------------------------------------------------------
  // Page selection: with two FULL pages the older one is the page the write
  // pointer has come back around to.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_pg  = 1'b0;
    for (int unsigned p = 0; p < NPG; p++) begin
      if (r_pg_st[p] == PG_FULL) begin
        if (!w_sel_vld || p[0] == w_wr_pg)
          w_sel_pg = p[0];
        w_sel_vld = 1'b1;
      end
    end
  end

  assign w_ack = (r_rd_st == RD_SERVE) & est_ack_nrs;

  // Write completion, read selection and ack always touch different pages,
  // so their updates can be applied independently.
  always_comb begin
    for (int unsigned p = 0; p < NPG; p++) begin
      w_pg_nxt[p] = r_pg_st[p];
      if (w_wr_acc && p[0] == w_wr_pg)
        w_pg_nxt[p] = w_wr_last ? PG_FULL : PG_FILLING;
      if (r_rd_st == RD_IDLE && w_sel_vld && p[0] == w_sel_pg)
        w_pg_nxt[p] = PG_READING;
      if (w_ack && p[0] == w_rd_pg)
        w_pg_nxt[p] = PG_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned p = 0; p < NPG; p++)
        r_pg_st[p] <= PG_EMPTY;
    end else begin
      for (int unsigned p = 0; p < NPG; p++)
        r_pg_st[p] <= w_pg_nxt[p];
    end
  end

  // ---------------------------------------------------------------------------
  // Read-side FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_rd_st <= RD_IDLE;
    else
      r_rd_st <= w_rd_nxt;
  end

  // SERVE always returns through IDLE, which guarantees the one-cycle gap
  // in NRS_gen_ready between consecutive pages.
  always_comb begin
    w_rd_nxt = r_rd_st;
    case (r_rd_st)
      RD_IDLE:  if (w_sel_vld)   w_rd_nxt = RD_SERVE;
      RD_SERVE: if (est_ack_nrs) w_rd_nxt = RD_IDLE;
      default:                   w_rd_nxt = RD_IDLE;
    endcase
  end

  always_comb begin
    w_serve = 1'b0;
    if (r_rd_st == RD_SERVE)
      w_serve = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Read data path (1-cycle latency, forced to 0 outside SERVE)
  // ---------------------------------------------------------------------------
  assign w_rd_idx = {nrs_index_addr, rd_addr_nrs};

  always_comb begin
    w_rd_data = r_mem0[w_rd_idx];
`ifdef NRS_PINGPONG_EN
    if (w_rd_pg)
      w_rd_data = r_mem1[w_rd_idx];
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_nrs_r <= 1'b0;
      r_nrs_i <= 1'b0;
    end else if (w_serve) begin
      r_nrs_r <= w_rd_data[1];
      r_nrs_i <= w_rd_data[0];
    end else begin
      r_nrs_r <= 1'b0;
      r_nrs_i <= 1'b0;
    end
  end

  assign gen_ready     = w_gen_ready;
  assign wr_err        = r_wr_err;
  assign NRS_gen_ready = w_serve;
  assign nrs_r         = r_nrs_r;
  assign nrs_i         = r_nrs_i;

endmodule

// File: tb/tb_nrs_buf.sv
module tb_nrs_buf;

`ifdef NRS_PINGPONG_EN
  localparam int NPG = 2;
`else
  localparam int NPG = 1;
`endif

  logic       clk;
  logic       rst;
  logic       gen_valid;
  logic       gen_nrs_r;
  logic       gen_nrs_i;
  logic       gen_ready;
  logic       wr_err;
  logic [1:0] nrs_index_addr;
  logic [3:0] rd_addr_nrs;
  logic       est_ack_nrs;
  logic       NRS_gen_ready;
  logic       nrs_r;
  logic       nrs_i;

  int    vec_cnt = 0;
  int    err_cnt = 0;
  string phase   = "init";

  // Reference model: a queue of completed pages (front = page being served
  // or next to serve), the page currently being collected, and flags.
  logic [127:0] m_q [$];
  logic [127:0] m_fill;
  int           m_fcnt;
  bit           m_serv;
  bit           m_err;
  logic [1:0]   m_rd;

  nrs_buf #(.NRS_ADDR(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .gen_valid      (gen_valid),
    .gen_nrs_r      (gen_nrs_r),
    .gen_nrs_i      (gen_nrs_i),
    .gen_ready      (gen_ready),
    .wr_err         (wr_err),
    .nrs_index_addr (nrs_index_addr),
    .rd_addr_nrs    (rd_addr_nrs),
    .est_ack_nrs    (est_ack_nrs),
    .NRS_gen_ready  (NRS_gen_ready),
    .nrs_r          (nrs_r),
    .nrs_i          (nrs_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic int unsigned ra();
    return $urandom_range(0, 63);
  endfunction

  function automatic void m_reset();
    m_q.delete();
    m_fill = '0;
    m_fcnt = 0;
    m_serv = 1'b0;
    m_err  = 1'b0;
    m_rd   = 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s/%s @%0t: observed %0h expected %0h", phase, tag, $time, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("gen_ready",     32'(gen_ready),     32'(m_q.size() < NPG));
    chk("NRS_gen_ready", 32'(NRS_gen_ready), 32'(m_serv));
    chk("nrs_r",         32'(nrs_r),         32'(m_rd[1]));
    chk("nrs_i",         32'(nrs_i),         32'(m_rd[0]));
    chk("wr_err",        32'(wr_err),        32'(m_err));
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, check
  // all outputs on the following falling edge.
  task automatic cyc(input bit v, input bit r, input bit i,
                     input int unsigned a, input bit ack);
    logic [127:0] pg;
    bit           rdy0;
    bit           srv0;
    int           qs0;
    gen_valid      = v;
    gen_nrs_r      = r;
    gen_nrs_i      = i;
    nrs_index_addr = a[5:4];
    rd_addr_nrs    = a[3:0];
    est_ack_nrs    = ack;
    @(posedge clk);
    qs0  = m_q.size();
    rdy0 = (qs0 < NPG);
    srv0 = m_serv;
    if (srv0) begin
      pg   = m_q[0];
      m_rd = pg[2*a +: 2];
    end else begin
      m_rd = 2'b00;
    end
    if (srv0 && ack) begin
      void'(m_q.pop_front());
      m_serv = 1'b0;
    end else if (!srv0 && qs0 != 0) begin
      m_serv = 1'b1;
    end
    if (v && rdy0) begin
      m_fill[2*m_fcnt +: 2] = {r, i};
      m_fcnt++;
      if (m_fcnt == 64) begin
        m_q.push_back(m_fill);
        m_fcnt = 0;
      end
    end else if (v) begin
      m_err = 1'b1;
    end
    @(negedge clk);
    gen_valid   = 1'b0;
    est_ack_nrs = 1'b0;
    chk_model();
  endtask

  initial begin
    gen_valid      = 1'b0;
    gen_nrs_r      = 1'b0;
    gen_nrs_i      = 1'b0;
    nrs_index_addr = 2'd0;
    rd_addr_nrs    = 4'd0;
    est_ack_nrs    = 1'b0;
    rst            = 1'b0;
    m_reset();

    // Reset values, then 10 idle cycles.
    phase = "reset";
    #1;
    chk("rst_gen_ready", 32'(gen_ready), 32'd1);
    chk("rst_ngr",       32'(NRS_gen_ready), 32'd0);
    chk("rst_nrs_r",     32'(nrs_r), 32'd0);
    chk("rst_nrs_i",     32'(nrs_i), 32'd0);
    chk("rst_wr_err",    32'(wr_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    phase = "idle";
    repeat (10) cyc(1'b0, 1'b0, 1'b0, ra(), 1'b0);

    // First page: {r,i} = index[1:0].
    phase = "fill_a";
    for (int k = 0; k < 64; k++) cyc(1'b1, k[1], k[0], ra(), 1'b0);
    chk("ngr_edge1", 32'(NRS_gen_ready), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, ra(), 1'b0);
    chk("ngr_edge2", 32'(NRS_gen_ready), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 37, 1'b0);
    chk("idx37_r", 32'(nrs_r), 32'd0);
    chk("idx37_i", 32'(nrs_i), 32'd1);

    // Second page with inverted pattern while reading the first one.
    phase = "fill_b";
    for (int k = 0; k < 64; k++) cyc(1'b1, ~k[1], ~k[0], ra(), 1'b0);
    repeat (8) cyc(1'b0, 1'b0, 1'b0, ra(), 1'b0);
    phase = "ack_a";
    cyc(1'b0, 1'b0, 1'b0, ra(), 1'b1);
    chk("ngr_gap", 32'(NRS_gen_ready), 32'd0);
    phase = "read_b";
    for (int k = 0; k < 64; k++) cyc(1'b0, 1'b0, 1'b0, k, 1'b0);

    // Overflow: fill the remaining capacity without ack, then keep pushing.
    phase = "overflow";
    for (int k = 0; k < 64; k++) cyc(1'b1, rb(), rb(), ra(), 1'b0);
    repeat (3) cyc(1'b1, rb(), rb(), ra(), 1'b0);
    chk("ovf_gen_ready", 32'(gen_ready), 32'd0);
    chk("ovf_wr_err",    32'(wr_err), 32'd1);
    for (int k = 0; k < 32; k++) cyc(1'b0, 1'b0, 1'b0, ra(), 1'b0);

    // Last write of a page on the same edge as the ack of the served page.
    phase = "simul";
    cyc(1'b0, 1'b0, 1'b0, ra(), 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, ra(), 1'b1);
    for (int k = 0; k < 63; k++) cyc(1'b1, rb(), rb(), ra(), 1'b0);
    cyc(1'b1, rb(), rb(), ra(), 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, ra(), 1'b0);
    for (int k = 0; k < 64; k++) cyc(1'b0, 1'b0, 1'b0, k, 1'b0);

    // Random traffic.
    phase = "random";
    for (int k = 0; k < 500; k++)
      cyc(($urandom_range(0, 9) < 6), rb(), rb(), ra(), ($urandom_range(0, 39) == 0));

    // Reset while serving.
    phase = "pre_reset";
    for (int t = 0; t < 300 && !m_serv; t++) cyc(1'b1, rb(), rb(), ra(), 1'b0);
    chk("serving_before_reset", 32'(NRS_gen_ready), 32'd1);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, ra(), 1'b0);
    phase = "mid_reset";
    #2;
    rst = 1'b0;
    m_reset();
    #1;
    chk("mr_gen_ready", 32'(gen_ready), 32'd1);
    chk("mr_ngr",       32'(NRS_gen_ready), 32'd0);
    chk("mr_nrs_r",     32'(nrs_r), 32'd0);
    chk("mr_nrs_i",     32'(nrs_i), 32'd0);
    chk("mr_wr_err",    32'(wr_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    phase = "refill";
    for (int k = 0; k < 64; k++) cyc(1'b1, rb(), rb(), ra(), 1'b0);
    cyc(1'b0, 1'b0, 1'b0, ra(), 1'b0);
    for (int k = 0; k < 64; k++) cyc(1'b0, 1'b0, 1'b0, k, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, ra(), 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, ra(), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/nrs_buf.md
# nrs_buf

Buffer on the responder side of the estimator's NRS read interface. Collects the serial NRS bit-pairs (real, imaginary) produced by the NRS generator, one bit-pair per cycle. Stores one full subframe's worth of pairs: 4 NRS columns × 2^NRS_ADDR entries. Signals `NRS_gen_ready` to the channel estimator, then serves its `nrs_index_addr`/`rd_addr_nrs` reads until the estimator returns `est_ack_nrs`.

## Interface
- NRS_ADDR, 4, entry-address width per NRS column; page holds 4·2^NRS_ADDR bit-pairs.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- gen_valid  in  1  generator presents a bit-pair this cycle.
- gen_nrs_r  in  1  real bit (1 = negative symbol, 0 = positive).
- gen_nrs_i  in  1  imaginary bit, same encoding.
- gen_ready  out  1  a free page exists; write accepted when gen_valid & gen_ready.
- wr_err  out  1  sticky: gen_valid seen while gen_ready low.
- nrs_index_addr  in  2  estimator column select (0..3).
- rd_addr_nrs  in  NRS_ADDR  estimator entry select.
- est_ack_nrs  in  1  single-cycle pulse: estimator done with current read page.
- NRS_gen_ready  out  1  a full page is available for reading.
- nrs_r  out  1  registered real bit of the addressed entry.
- nrs_i  out  1  registered imaginary bit of the addressed entry.

## Operation
- Storage: 2 pages (see Configuration), each 4 columns × 2^NRS_ADDR × 2 bits; flat write index = {column, entry}.
- Write counter wr_cnt, width 2+NRS_ADDR, starts at 0. Each accepted write stores into wr_page[wr_cnt], then increments wr_cnt. Order: column 0 entries 0..2^NRS_ADDR−1, then column 1, and so on.
- When wr_cnt wraps from all-ones to 0, the write page is marked full and the write pointer toggles to the other page.
- Page states: EMPTY → FILLING (first accepted write) → FULL (last write) → READING (selected by read side) → EMPTY (est_ack_nrs).
- Read side FSM has two states:
  - IDLE: NRS_gen_ready=0. Moves to SERVE when any page is FULL. The oldest FULL page becomes the read page.
  - SERVE: NRS_gen_ready=1. On est_ack_nrs, the read page goes to EMPTY and the FSM returns to IDLE.
- gen_ready = write page not FULL/READING, i.e. a page is EMPTY or FILLING.
- Writes without gen_ready are dropped: wr_cnt holds and wr_err is set. wr_err is cleared only by reset.
- est_ack_nrs in IDLE is ignored.

## Timing
- Reset values: gen_ready=1, wr_err=0, NRS_gen_ready=0, nrs_r=0, nrs_i=0; all pages EMPTY; wr_cnt=0; FSM=IDLE. Memory contents are don't-care.
- Read latency 1: address presented in cycle n, data on nrs_r/nrs_i after edge n+1. Back-to-back addresses every cycle are supported.
- In IDLE, nrs_r/nrs_i are registered to 0.
- Last write in cycle n:
  - page is FULL after edge n+1;
  - NRS_gen_ready=1 after edge n+2, provided the FSM was IDLE.
- est_ack_nrs at edge n drops NRS_gen_ready after edge n+1. It is then low for at least one cycle, even if the other page is FULL, and reasserts after edge n+2 at the earliest.
- Freed page → gen_ready=1 after edge n+1.
- Simultaneous last write and est_ack_nrs on the same edge: both take effect.
  - The acked page goes EMPTY.
  - The newly filled page goes FULL and is served after the mandatory idle cycle.
- Reset asserted mid-fill or mid-read: everything returns to reset values immediately (asynchronous); any partial page is discarded.

## Configuration
- NRS_PINGPONG_EN defined: two pages; the generator may fill one page while the estimator reads the other.
- NRS_PINGPONG_EN undefined:
  - single page; gen_ready=0 from the last write until est_ack_nrs;
  - the same state rules apply with one page;
  - the page toggle logic and the second memory are not built.

## Test plan
- Reset then idle: check gen_ready=1, NRS_gen_ready=0, nrs_r=nrs_i=0, wr_err=0 for 10 cycles.
- Fill 64 pairs (NRS_ADDR=4) with pattern {r,i}=index[1:0]:
  - NRS_gen_ready rises 2 cycles after the 64th write.
  - Read column 2, entry 5 (index 37): nrs_r=0, nrs_i=1 one cycle later.
- Ping-pong (macro on):
  - Fill page A, then fill page B with the inverted pattern while reading A; gen_ready stays 1 during the B fill.
  - After est_ack_nrs: NRS_gen_ready low exactly 1 cycle, then B's data is read back inverted.
- Overflow:
  - Macro on: fill both pages with no ack, then pulse gen_valid → gen_ready=0, wr_err=1, stored data unchanged.
  - Macro off: same result after one page.
- Simultaneous: last write of B on the same edge as est_ack_nrs for A → A freed (gen_ready=1), B served after the idle cycle.
- Reset mid-read: drop rst while NRS_gen_ready=1 → all outputs at reset values in the same cycle; after release, a fresh 64-write fill is served correctly.
